// File: rtl/key_mon_pkg.sv
// Shared definitions for the key tamper monitor: FSM states and default widths.
package key_mon_pkg;

    localparam int KEY_W_DEF  = 56;
    localparam int TRIG_W_DEF = 32;
    localparam int WEIGHT_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_SUSPECT = 2'd2,
        ST_ALARM   = 2'd3
    } state_t;

endpackage

// File: rtl/key_diff_weight.sv
// Combinational popcount of the key difference vector.
import key_mon_pkg::*;

module key_diff_weight #(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic [KEY_W-1:0]    diff,
    output logic [WEIGHT_W-1:0] weight
);

    logic [WEIGHT_W-1:0] partial [0:KEY_W];

    assign partial[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < KEY_W; gi++) begin : g_pop
            assign partial[gi+1] = partial[gi] + {{(WEIGHT_W-1){1'b0}}, diff[gi]};
        end
    endgenerate

    assign weight = partial[KEY_W];

endmodule

// File: rtl/key_tamper_detector.sv
// Compares every key delivered to the cipher against a captured golden key,
// counts corruptions and raises a sticky alarm at a programmable threshold.
import key_mon_pkg::*;

module key_tamper_detector #(
    parameter int KEY_W        = KEY_W_DEF,
    parameter int TRIG_W       = TRIG_W_DEF,
    parameter int CNT_W        = 8,
    parameter int ALARM_THRESH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_load,
    input  logic [KEY_W-1:0]    golden_key,
    input  logic                obs_valid,
    input  logic [KEY_W-1:0]    obs_key,
    input  logic [TRIG_W-1:0]   obs_trigger,
    input  logic                clear,
    output logic                mismatch,
    output logic [KEY_W-1:0]    diff_mask,
    output logic [WEIGHT_W-1:0] diff_weight,
    output logic [TRIG_W-1:0]   first_trigger,
    output logic [CNT_W-1:0]    mismatch_cnt,
    output logic                alarm,
    output logic [1:0]          state
);

    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ALARM_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              state_reg;
    logic [KEY_W-1:0]    golden_reg;
    logic [KEY_W-1:0]    diff_mask_reg;
    logic [WEIGHT_W-1:0] diff_weight_reg;
    logic [TRIG_W-1:0]   first_trigger_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                mismatch_reg;
    logic                alarm_reg;

    logic [KEY_W-1:0]    diff_next;
    logic [WEIGHT_W-1:0] weight_next;
    logic [CNT_W-1:0]    cnt_next;

    assign diff_next = obs_key ^ golden_reg;
    assign cnt_next  = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

    key_diff_weight #(.KEY_W(KEY_W)) u_weight (
        .diff   (diff_next),
        .weight (weight_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            golden_reg        <= '0;
            diff_mask_reg     <= '0;
            diff_weight_reg   <= '0;
            first_trigger_reg <= '0;
            cnt_reg           <= '0;
            mismatch_reg      <= 1'b0;
            alarm_reg         <= 1'b0;
        end else begin
            mismatch_reg <= 1'b0;
            if (clear || key_load) begin
                // Any observation arriving alongside a load or clear is dropped.
                if (clear) begin
                    cnt_reg           <= '0;
                    alarm_reg         <= 1'b0;
                    first_trigger_reg <= '0;
                    diff_mask_reg     <= '0;
                    diff_weight_reg   <= '0;
                    state_reg         <= (state_reg == ST_IDLE) ? ST_IDLE : ST_ARMED;
                end
                // A lone load cannot clear an alarm; clear+load reloads from any state.
                if (key_load && (clear || state_reg != ST_ALARM)) begin
                    golden_reg        <= golden_key;
                    cnt_reg           <= '0;
                    first_trigger_reg <= '0;
                    state_reg         <= ST_ARMED;
                end
            end else if (obs_valid && state_reg != ST_IDLE) begin
                diff_mask_reg   <= diff_next;
                diff_weight_reg <= weight_next;
                if (diff_next != '0) begin
                    mismatch_reg <= 1'b1;
                    cnt_reg      <= cnt_next;
                    if (state_reg != ST_ALARM) begin
                        if (state_reg == ST_ARMED)
                            first_trigger_reg <= obs_trigger;
                        if (cnt_next >= THRESH) begin
                            state_reg <= ST_ALARM;
                            alarm_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_SUSPECT;
                        end
                    end
                end
            end
        end
    end

    assign mismatch      = mismatch_reg;
    assign diff_mask     = diff_mask_reg;
    assign diff_weight   = diff_weight_reg;
    assign first_trigger = first_trigger_reg;
    assign mismatch_cnt  = cnt_reg;
    assign alarm         = alarm_reg;
    assign state         = state_reg;

endmodule

// File: tb/tb_key_tamper_detector.sv
// Randomised scoreboard bench for key_tamper_detector; two instances (threshold 3 and 1) share stimulus.
module tb_key_tamper_detector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_load = 1'b0;
    logic [55:0] golden_key = '0;
    logic        obs_valid = 1'b0;
    logic [55:0] obs_key = '0;
    logic [31:0] obs_trigger = '0;
    logic        clear = 1'b0;

    logic        mm0, mm1, al0, al1;
    logic [55:0] dm0, dm1;
    logic [5:0]  dw0, dw1;
    logic [31:0] ft0, ft1;
    logic [7:0]  cn0, cn1;
    logic [1:0]  st0, st1;

    always #5 clk = ~clk;

    key_tamper_detector #(.ALARM_THRESH(3)) u0 (
        .clk(clk), .rst(rst), .key_load(key_load), .golden_key(golden_key),
        .obs_valid(obs_valid), .obs_key(obs_key), .obs_trigger(obs_trigger), .clear(clear),
        .mismatch(mm0), .diff_mask(dm0), .diff_weight(dw0), .first_trigger(ft0),
        .mismatch_cnt(cn0), .alarm(al0), .state(st0)
    );

    key_tamper_detector #(.ALARM_THRESH(1)) u1 (
        .clk(clk), .rst(rst), .key_load(key_load), .golden_key(golden_key),
        .obs_valid(obs_valid), .obs_key(obs_key), .obs_trigger(obs_trigger), .clear(clear),
        .mismatch(mm1), .diff_mask(dm1), .diff_weight(dw1), .first_trigger(ft1),
        .mismatch_cnt(cn1), .alarm(al1), .state(st1)
    );

    typedef struct packed {
        logic        mismatch;
        logic [55:0] dm;
        logic [5:0]  dw;
        logic [31:0] ft;
        logic [7:0]  cnt;
        logic        alarm;
        logic [1:0]  st;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int tests = 0;
    int fails = 0;

    // Reference model: unbounded mismatch count per instance, everything else derived from it.
    logic [55:0] m_golden [2];
    bit          m_have   [2];
    int          m_cnt    [2];
    bit          m_alarm  [2];
    logic [31:0] m_first  [2];
    logic [55:0] m_dm     [2];
    int          m_thr    [2] = '{3, 1};

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_golden[i] = '0; m_have[i] = 0; m_cnt[i] = 0;
            m_alarm[i] = 0; m_first[i] = '0; m_dm[i] = '0;
        end
    endtask

    function automatic exp_t model_exp(int i, bit mism);
        exp_t e;
        e.mismatch = mism;
        e.dm       = m_dm[i];
        e.dw       = 6'($countones(m_dm[i]));
        e.ft       = m_first[i];
        e.cnt      = (m_cnt[i] > 255) ? 8'd255 : 8'(m_cnt[i]);
        e.alarm    = m_alarm[i];
        if (!m_have[i])       e.st = 2'd0;
        else if (m_alarm[i])  e.st = 2'd3;
        else if (m_cnt[i]==0) e.st = 2'd1;
        else                  e.st = 2'd2;
        return e;
    endfunction

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s u%0d @%0t: got %h expected %h", name, inst, $time, act, exp);
        end
    endtask

    task automatic check_inst(input int i, input exp_t e);
        exp_t a;
        if (i == 0) a = '{mm0, dm0, dw0, ft0, cn0, al0, st0};
        else        a = '{mm1, dm1, dw1, ft1, cn1, al1, st1};
        chk("mismatch",      i, 64'(a.mismatch), 64'(e.mismatch));
        chk("diff_mask",     i, 64'(a.dm),       64'(e.dm));
        chk("diff_weight",   i, 64'(a.dw),       64'(e.dw));
        chk("first_trigger", i, 64'(a.ft),       64'(e.ft));
        chk("mismatch_cnt",  i, 64'(a.cnt),      64'(e.cnt));
        chk("alarm",         i, 64'(a.alarm),    64'(e.alarm));
        chk("state",         i, 64'(a.st),       64'(e.st));
    endtask

    // Monitor: outputs are registered, so each pushed transaction is visible just after the next edge.
    always @(posedge clk) begin
        #1;
        if (q0.size() > 0 && q1.size() > 0) begin
            check_inst(0, q0.pop_front());
            check_inst(1, q1.pop_front());
        end
    end

    task automatic step(input string tag, input bit kl, input logic [55:0] gk, input bit ov,
                        input logic [55:0] ok, input logic [31:0] ot, input bit cl);
        bit   mism;
        logic [55:0] d;
        @(negedge clk);
        key_load = kl; golden_key = gk; obs_valid = ov;
        obs_key = ok; obs_trigger = ot; clear = cl;
        for (int i = 0; i < 2; i++) begin
            mism = 0;
            if (cl || kl) begin
                if (cl) begin
                    m_cnt[i] = 0; m_alarm[i] = 0; m_first[i] = '0; m_dm[i] = '0;
                end
                if (kl && (cl || !m_alarm[i])) begin
                    m_golden[i] = gk; m_have[i] = 1; m_cnt[i] = 0; m_first[i] = '0;
                end
            end else if (ov && m_have[i]) begin
                d = ok ^ m_golden[i];
                m_dm[i] = d;
                if (d != '0) begin
                    mism = 1;
                    if (m_cnt[i] == 0) m_first[i] = ot;
                    m_cnt[i]++;
                    if (m_cnt[i] >= m_thr[i]) m_alarm[i] = 1;
                end
            end
            if (i == 0) q0.push_back(model_exp(0, mism));
            else        q1.push_back(model_exp(1, mism));
        end
        if (tag != "")
            $display("[TB] %s kl=%0b cl=%0b ov=%0b key=%h trig=%h", tag, kl, cl, ov, ok, ot);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_mismatch"}, 0, 64'(mm0), 64'(0));
        chk({name, "_diff"},     0, 64'(dm0), 64'(0));
        chk({name, "_weight"},   0, 64'(dw0), 64'(0));
        chk({name, "_first"},    0, 64'(ft0), 64'(0));
        chk({name, "_cnt"},      0, 64'(cn0), 64'(0));
        chk({name, "_alarm"},    0, 64'(al0), 64'(0));
        chk({name, "_state"},    0, 64'(st0), 64'(0));
        chk({name, "_state"},    1, 64'(st1), 64'(0));
        chk({name, "_cnt"},      1, 64'(cn1), 64'(0));
    endtask

    localparam logic [55:0] GK  = 56'h0123456789ABCD;
    localparam logic [55:0] GK2 = 56'hA5A5A5A5A5A5A5;

    initial begin
        logic [63:0] r64;
        logic [55:0] pool [4];
        logic [55:0] ok;
        logic [55:0] gk;
        int          timeout;

        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");

        // IDLE ignores observations.
        step("idle_obs", 0, '0, 1, 56'hDEADBEEF123456, 32'h77, 0);
        step("load", 1, GK, 0, '0, '0, 0);
        repeat (3) step("match", 0, '0, 1, GK, 32'h1, 0);
        step("flip0_t5",  0, '0, 1, GK ^ 56'h1, 32'h5, 0);
        step("flip0_t15", 0, '0, 1, GK ^ 56'h1, 32'h15, 0);
        step("flip0_t25", 0, '0, 1, GK ^ 56'h1, 32'h25, 0);
        step("load_in_alarm", 1, GK2, 0, '0, '0, 0);
        step("clear", 0, '0, 0, '0, '0, 1);
        step("load_with_obs", 1, GK, 1, GK ^ 56'hF0, 32'h9, 0);
        step("clear_with_obs", 0, '0, 1, GK ^ 56'h3, 32'hA, 1);
        step("suspect", 0, '0, 1, GK ^ 56'h2, 32'h33, 0);

        // Asynchronous reset in the middle of a cycle.
        @(negedge clk);
        key_load = 0; obs_valid = 0; clear = 0;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        #2 rst = 1'b0;

        step("reload", 1, GK, 0, '0, '0, 0);
        step("wide_diff", 0, '0, 1, GK ^ 56'hFF00000000000F, 32'hC0DE, 0);
        for (int n = 0; n < 300; n++)
            step("", 0, '0, 1, GK ^ 56'(n + 1), 32'(n), 0);
        step("after_sat", 0, '0, 1, GK ^ 56'h80, 32'h1, 0);
        step("clear_load_alarm", 1, GK2, 1, GK2 ^ 56'h1, 32'h2, 1);
        step("match2", 0, '0, 1, GK2, 32'h3, 0);

        // Randomised traffic: a few golden keys, observations mostly correct or lightly corrupted.
        for (int i = 0; i < 4; i++) begin
            r64 = {$urandom, $urandom};
            pool[i] = r64[55:0];
        end
        for (int n = 0; n < 600; n++) begin
            gk = pool[$urandom_range(0, 3)];
            r64 = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0, 1: ok = m_golden[0];
                2:    ok = m_golden[0] ^ (56'h1 << $urandom_range(0, 55));
                default: ok = r64[55:0];
            endcase
            step("", $urandom_range(0, 99) < 8, gk, $urandom_range(0, 99) < 70,
                 ok, $urandom, $urandom_range(0, 99) < 5);
        end

        @(negedge clk);
        key_load = 0; obs_valid = 0; clear = 0;
        timeout = 0;
        while (q0.size() > 0 && timeout < 10) begin
            @(negedge clk);
            timeout++;
        end
        chk("drain", 0, 64'(q0.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
